// File: rtl/move_gen_leaper_pkg.sv
// Shared constants for the leaper move generator: piece type codes, offset tables and FSM states.
// Sliding-piece generators are expected to import the same type codes.
package move_gen_leaper_pkg;

    localparam int OFF_W = 3;

    localparam logic [2:0] PT_EMPTY   = 3'd0;
    localparam logic [2:0] PT_PAWN    = 3'd1;
    localparam logic [2:0] PT_KNIGHT  = 3'd2;
    localparam logic [2:0] PT_BISHOP  = 3'd3;
    localparam logic [2:0] PT_ROOK    = 3'd4;
    localparam logic [2:0] PT_QUEEN   = 3'd5;
    localparam logic [2:0] PT_KING    = 3'd6;
    localparam logic [2:0] PT_INVALID = 3'd7;

    // Offsets as (dcol, drow), walked in index order 0..7
    localparam logic signed [OFF_W-1:0] KNIGHT_DCOL [8] =
        '{3'sd1, 3'sd2, 3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1};
    localparam logic signed [OFF_W-1:0] KNIGHT_DROW [8] =
        '{3'sd2, 3'sd1, -3'sd1, -3'sd2, -3'sd2, -3'sd1, 3'sd1, 3'sd2};
    localparam logic signed [OFF_W-1:0] KING_DCOL [8] =
        '{3'sd0, 3'sd1, 3'sd1, 3'sd1, 3'sd0, -3'sd1, -3'sd1, -3'sd1};
    localparam logic signed [OFF_W-1:0] KING_DROW [8] =
        '{3'sd1, 3'sd1, 3'sd0, -3'sd1, -3'sd1, -3'sd1, 3'sd0, 3'sd1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_EMIT  = 3'd5,
        ST_FIN   = 3'd6
    } state_e;

endpackage

// File: rtl/move_gen_leaper_offset_rom.sv
// Combinational offset lookup: (idx, mode) -> signed (dcol, drow) for knight or king.
module leaper_offset_rom
    import move_gen_leaper_pkg::*;
(
    input  logic [2:0]              idx_i,
    input  logic                    mode_i,
    output logic signed [OFF_W-1:0] dcol_o,
    output logic signed [OFF_W-1:0] drow_o
);

    // Table select: mode 1 walks the king ring, mode 0 the knight jumps
    always_comb begin
        dcol_o = {OFF_W{1'b0}};
        drow_o = {OFF_W{1'b0}};
        if (mode_i) begin
            dcol_o = KING_DCOL[idx_i];
            drow_o = KING_DROW[idx_i];
        end else begin
            dcol_o = KNIGHT_DCOL[idx_i];
            drow_o = KNIGHT_DROW[idx_i];
        end
    end

endmodule

// File: rtl/move_gen_leaper.sv
// Leaper move generator: walks the 8 offsets of one knight/king, reads each target square
// and streams quiet moves and captures over a valid/ready interface.
module move_gen_leaper
    import move_gen_leaper_pkg::*;
#(
    parameter int  COORD_W   = 3,
    parameter int  BOARD_DIM = 8,
    parameter int  TYPE_W    = 3,
    parameter int  MOVE_W    = 16,
    localparam int PIECE_W   = TYPE_W + 2*COORD_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [PIECE_W-1:0] src_piece_i,
    input  logic               mode_i,
    input  logic               turn_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [3:0]         move_count_o,
    output logic               rd_en_o,
    output logic [COORD_W-1:0] rd_col_o,
    output logic [COORD_W-1:0] rd_row_o,
    input  logic [PIECE_W-1:0] rd_piece_i,
    output logic               move_valid_o,
    input  logic               move_ready_i,
    output logic [MOVE_W-1:0]  move_data_o
);

    // Two guard bits keep src + offset from wrapping into a false on-board value
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] DIM_S = SW'(BOARD_DIM);

    state_e               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [3:0]           count_q, count_d;
    logic [3:0]           move_count_q, move_count_d;
    logic [PIECE_W-1:0]   src_q, src_d;
    logic                 mode_q, mode_d;
    logic                 turn_q, turn_d;
    logic                 busy_q, done_q, move_valid_q;
    logic                 rd_en_q, rd_en_d;
    logic [COORD_W-1:0]   rd_col_q, rd_col_d, rd_row_q, rd_row_d;
    logic [MOVE_W-1:0]    move_data_q, move_data_d, move_word_s;

    logic [TYPE_W-1:0]    src_type_s, tgt_type_s;
    logic [COORD_W-1:0]   src_col_s, src_row_s;
    logic                 src_color_s, tgt_color_s;
    logic signed [OFF_W-1:0] dcol_s, drow_s;
    logic signed [SW-1:0] tgt_col_s, tgt_row_s;
    logic                 src_ok_s, on_board_s, legal_s, capture_s, last_s;
    logic                 unused_rd_bits_s;

    leaper_offset_rom u_rom (
        .idx_i  (idx_q),
        .mode_i (mode_q),
        .dcol_o (dcol_s),
        .drow_o (drow_s)
    );

    assign src_type_s  = src_q[PIECE_W-1 -: TYPE_W];
    assign src_col_s   = src_q[2*COORD_W -: COORD_W];
    assign src_row_s   = src_q[COORD_W -: COORD_W];
    assign src_color_s = src_q[0];
    assign tgt_type_s  = rd_piece_i[PIECE_W-1 -: TYPE_W];
    assign tgt_color_s = rd_piece_i[0];
    assign unused_rd_bits_s = ^rd_piece_i[2*COORD_W:1];

    assign tgt_col_s = $signed({2'b00, src_col_s}) + $signed({{(SW-OFF_W){dcol_s[OFF_W-1]}}, dcol_s});
    assign tgt_row_s = $signed({2'b00, src_row_s}) + $signed({{(SW-OFF_W){drow_s[OFF_W-1]}}, drow_s});

    assign on_board_s = !tgt_col_s[SW-1] && (tgt_col_s < DIM_S) &&
                        !tgt_row_s[SW-1] && (tgt_row_s < DIM_S);
    assign src_ok_s   = (mode_q ? (src_type_s == TYPE_W'(PT_KING)) : (src_type_s == TYPE_W'(PT_KNIGHT)))
                        && (src_color_s == turn_q);
    assign capture_s  = (tgt_type_s != TYPE_W'(PT_EMPTY));
    assign legal_s    = (tgt_type_s != TYPE_W'(PT_INVALID)) && (!capture_s || (tgt_color_s != turn_q));
    assign last_s     = (idx_q == 3'd7);

    // Move word from the latched read address; promo is always 0 for leapers
    always_comb begin
        move_word_s = {MOVE_W{1'b0}};
        move_word_s[COORD_W-1:0]           = rd_row_q;
        move_word_s[2*COORD_W-1:COORD_W]   = rd_col_q;
        move_word_s[3*COORD_W-1:2*COORD_W] = src_row_s;
        move_word_s[4*COORD_W-1:3*COORD_W] = src_col_s;
        move_word_s[4*COORD_W]             = capture_s;
        move_word_s[4*COORD_W+1]           = 1'b0;
    end

    // Next-state logic for the offset walk
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        src_d       = src_q;
        mode_d      = mode_q;
        turn_d      = turn_q;
        rd_en_d     = 1'b0;
        rd_col_d    = rd_col_q;
        rd_row_d    = rd_row_q;
        move_data_d = move_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = src_piece_i;
                    mode_d  = mode_i;
                    turn_d  = turn_i;
                    idx_d   = 3'd0;
                    count_d = 4'd0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (src_ok_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_ISSUE: begin
                if (on_board_s) begin
                    rd_en_d  = 1'b1;
                    rd_col_d = tgt_col_s[COORD_W-1:0];
                    rd_row_d = tgt_row_s[COORD_W-1:0];
                    state_d  = ST_WAIT;
                end else if (last_s) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (legal_s) begin
                    move_data_d = move_word_s;
                    state_d     = ST_EMIT;
                end else if (last_s) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_EMIT: begin
                if (move_ready_i) begin
                    count_d = count_q + 4'd1;
                    if (last_s) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Published count only changes on the way into FIN
    always_comb begin
        move_count_d = move_count_q;
        if (state_d == ST_FIN) begin
            move_count_d = count_d;
        end else begin
            move_count_d = move_count_q;
        end
    end

    // State and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            count_q      <= 4'd0;
            move_count_q <= 4'd0;
            src_q        <= {PIECE_W{1'b0}};
            mode_q       <= 1'b0;
            turn_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_col_q     <= {COORD_W{1'b0}};
            rd_row_q     <= {COORD_W{1'b0}};
            move_valid_q <= 1'b0;
            move_data_q  <= {MOVE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            move_count_q <= move_count_d;
            src_q        <= src_d;
            mode_q       <= mode_d;
            turn_q       <= turn_d;
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_FIN);
            done_q       <= (state_d == ST_FIN);
            rd_en_q      <= rd_en_d;
            rd_col_q     <= rd_col_d;
            rd_row_q     <= rd_row_d;
            move_valid_q <= (state_d == ST_EMIT);
            move_data_q  <= move_data_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign move_count_o = move_count_q;
    assign rd_en_o      = rd_en_q;
    assign rd_col_o     = rd_col_q;
    assign rd_row_o     = rd_row_q;
    assign move_valid_o = move_valid_q;
    assign move_data_o  = move_data_q;

endmodule

// File: tb/tb_move_gen_leaper.sv
// Randomized bench for move_gen_leaper against a square-by-square reference of the leaper rules.
module tb_move_gen_leaper;
    import move_gen_leaper_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, mode, turn, move_ready;
    logic [9:0]  src_piece, rd_piece;
    logic        busy, done, rd_en, move_valid;
    logic [3:0]  move_count;
    logic [2:0]  rd_col, rd_row;
    logic [15:0] move_data;

    logic [9:0]  board [8][8];
    int          total = 0;
    int          bad   = 0;

    int knt_dc [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    int knt_dr [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    int kng_dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int kng_dr [8] = '{1, 1, 0, -1, -1, -1, 0, 1};

    always #5 clk = ~clk;

    // Board RAM: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) rd_piece <= board[rd_col][rd_row];
    end

    move_gen_leaper dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src_piece_i  (src_piece),
        .mode_i       (mode),
        .turn_i       (turn),
        .busy_o       (busy),
        .done_o       (done),
        .move_count_o (move_count),
        .rd_en_o      (rd_en),
        .rd_col_o     (rd_col),
        .rd_row_o     (rd_row),
        .rd_piece_i   (rd_piece),
        .move_valid_o (move_valid),
        .move_ready_i (move_ready),
        .move_data_o  (move_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk(input logic [2:0] typ, input logic [2:0] c, input logic [2:0] r,
                                      input logic color);
        return {typ, c, r, color};
    endfunction

    task automatic clear_board();
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                board[c][r] = mk(PT_EMPTY, 3'($urandom), 3'($urandom), 1'($urandom));
    endtask

    task automatic random_board();
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                if ($urandom_range(0, 1) == 0)
                    board[c][r] = mk(PT_EMPTY, 3'($urandom), 3'($urandom), 1'($urandom));
                else
                    board[c][r] = mk(3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom), 1'($urandom));
    endtask

    // One request: build the expected move list and read addresses, then drive and observe
    task automatic run_req(input logic [9:0] src, input logic md, input logic tn,
                           input int rdy_rand, input int stall_at, input int stall_len,
                           input bit poke, input bit expect_reject);
        logic [15:0] exp_q [$];
        logic [5:0]  exp_rd [$];
        logic [15:0] got_q [$];
        logic [15:0] held;
        logic [9:0]  p;
        int sc, sr, tc, tr, dc, dr, stall_left, done_n;
        bit fin, was_stall, ok;
        sc = int'(src[6:4]);
        sr = int'(src[3:1]);
        ok = (md ? (src[9:7] == PT_KING) : (src[9:7] == PT_KNIGHT)) && (src[0] == tn);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                dc = md ? kng_dc[i] : knt_dc[i];
                dr = md ? kng_dr[i] : knt_dr[i];
                tc = sc + dc;
                tr = sr + dr;
                if (tc >= 0 && tc < 8 && tr >= 0 && tr < 8) begin
                    p = board[tc][tr];
                    exp_rd.push_back({3'(tc), 3'(tr)});
                    if (p[9:7] == PT_EMPTY)
                        exp_q.push_back({2'b00, 1'b0, 1'b0, 3'(sc), 3'(sr), 3'(tc), 3'(tr)});
                    else if (p[9:7] != PT_INVALID && p[0] != tn)
                        exp_q.push_back({2'b00, 1'b0, 1'b1, 3'(sc), 3'(sr), 3'(tc), 3'(tr)});
                end
            end
        end

        @(negedge clk);
        start = 1'b1; src_piece = src; mode = md; turn = tn;
        @(negedge clk);
        start = 1'b0; src_piece = 10'($urandom); mode = ~md; turn = ~tn;
        chk("busy_up", 32'(busy), 32'd1);
        fin = 1'b0; was_stall = 1'b0; stall_left = stall_len; done_n = 0; held = 16'd0;
        for (int n = 1; n < 400 && !fin; n++) begin
            if (n > 1) @(negedge clk);
            if (rd_en) begin
                if (exp_rd.size() > 0) chk("rd_addr", 32'({rd_col, rd_row}), 32'(exp_rd.pop_front()));
                else chk("rd_extra", 32'(rd_en), 32'd0);
            end
            if (was_stall) begin
                chk("stall_valid", 32'(move_valid), 32'd1);
                chk("stall_data", 32'(move_data), 32'(held));
                chk("stall_rd", 32'(rd_en), 32'd0);
            end
            was_stall = 1'b0;
            if (done) begin
                fin = 1'b1;
                done_n = n;
                start = 1'b0;
                chk("busy_fin", 32'(busy), 32'd0);
            end else begin
                if (move_valid && got_q.size() == stall_at && stall_left > 0) begin
                    move_ready = 1'b0;
                    stall_left--;
                end else if (rdy_rand != 0) begin
                    move_ready = 1'($urandom_range(0, 1));
                end else begin
                    move_ready = 1'b1;
                end
                if (move_valid) begin
                    if (move_ready) got_q.push_back(move_data);
                    else begin
                        was_stall = 1'b1;
                        held = move_data;
                    end
                end
                if (poke) begin
                    start = 1'($urandom_range(0, 1));
                    src_piece = 10'($urandom);
                end
            end
        end
        if (!fin) chk("timeout_done", 32'(done), 32'd1);
        chk("move_count", 32'(move_count), 32'(exp_q.size()));
        chk("num_moves", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("move_word", 32'(got_q[i]), 32'(exp_q[i]));
        chk("reads_missing", 32'(exp_rd.size()), 32'd0);
        if (expect_reject) chk("reject_done_cyc", 32'(done_n), 32'd2);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        move_ready = 1'b1;
    endtask

    initial begin
        logic [2:0] t;
        logic md;
        rst = 1'b1; start = 1'b0; mode = 1'b0; turn = 1'b0; move_ready = 1'b1; src_piece = 10'd0;
        clear_board();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_valid", 32'(move_valid), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_data", 32'(move_data), 32'd0);
        rst = 1'b0;

        // Knight in the centre of an empty board: all 8 quiet moves
        run_req(mk(PT_KNIGHT, 3'd3, 3'd3, 1'b0), 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b0);
        // Corner knight: only two on-board targets
        run_req(mk(PT_KNIGHT, 3'd0, 3'd0, 1'b0), 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b0);
        // King with one enemy and one friendly neighbour
        board[5][5] = mk(PT_KNIGHT, 3'd5, 3'd5, 1'b1);
        board[4][5] = mk(PT_PAWN, 3'd4, 3'd5, 1'b0);
        run_req(mk(PT_KING, 3'd4, 3'd4, 1'b0), 1'b1, 1'b0, 0, -1, 0, 1'b0, 1'b0);
        // Source colour differs from side to move
        run_req(mk(PT_KNIGHT, 3'd3, 3'd3, 1'b1), 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b1);
        // Consumer stalls 10 cycles on the second move
        clear_board();
        run_req(mk(PT_KNIGHT, 3'd3, 3'd3, 1'b0), 1'b0, 1'b0, 0, 1, 10, 1'b0, 1'b0);

        // Reset while a read is in flight, then a clean rerun
        @(negedge clk);
        start = 1'b1; src_piece = mk(PT_KNIGHT, 3'd3, 3'd3, 1'b0); mode = 1'b0; turn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 20 && !rd_en; n++) @(negedge clk);
        chk("wait_reached", 32'(rd_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(move_valid), 32'd0);
        chk("midrst_rd_en", 32'(rd_en), 32'd0);
        rst = 1'b0;
        run_req(mk(PT_KNIGHT, 3'd3, 3'd3, 1'b0), 1'b0, 1'b0, 0, -1, 0, 1'b0, 1'b0);

        // Random boards, pieces, readiness and ignored start pulses while busy
        for (int k = 0; k < 30; k++) begin
            random_board();
            case ($urandom_range(0, 3))
                0: t = PT_KNIGHT;
                1: t = PT_KING;
                2: t = PT_KING;
                default: t = 3'($urandom);
            endcase
            md = (t == PT_KING) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            run_req(mk(t, 3'($urandom), 3'($urandom), 1'($urandom)), md, 1'($urandom),
                    1, -1, 0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
